// File: rtl/matrix_mac_engine.sv
// matrix_mac_engine: sequential signed matrix multiplier C = A x B built around a
// single time-shared multiply-accumulate unit. A and B are written through the
// load port while idle; start runs ROWS_A*COLS_B*COLS_A MAC cycles, each finished
// dot product is saturated to W_OUT bits into C, and C is read through a
// registered port.
module matrix_mac_engine #(
  parameter int W_IN   = 8,
  parameter int W_OUT  = 17,
  parameter int ROWS_A = 2,
  parameter int COLS_A = 2,
  parameter int COLS_B = 2,
  localparam int R_MAX = (ROWS_A > COLS_A) ? ROWS_A : COLS_A,
  localparam int C_MAX = (COLS_A > COLS_B) ? COLS_A : COLS_B,
  localparam int RW    = ($clog2(R_MAX) < 1) ? 1 : $clog2(R_MAX),
  localparam int CW    = ($clog2(C_MAX) < 1) ? 1 : $clog2(C_MAX),
  localparam int RRW   = ($clog2(ROWS_A) < 1) ? 1 : $clog2(ROWS_A),
  localparam int RCW   = ($clog2(COLS_B) < 1) ? 1 : $clog2(COLS_B)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_valid,
  input  logic                    load_sel,
  input  logic [RW-1:0]           load_row,
  input  logic [CW-1:0]           load_col,
  input  logic signed [W_IN-1:0]  load_data,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    sat_flag,
  input  logic [RRW-1:0]          rd_row,
  input  logic [RCW-1:0]          rd_col,
  output logic signed [W_OUT-1:0] rd_data
);

  // Accumulator is wide enough to hold any COLS_A-term dot product exactly.
  localparam int W_ACC = 2 * W_IN + $clog2(COLS_A) + 1;
  localparam int KW    = ($clog2(COLS_A) < 1) ? 1 : $clog2(COLS_A);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COMPUTE = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  logic [1:0]              state_r;
  logic signed [W_IN-1:0]  a_r [ROWS_A][COLS_A];
  logic signed [W_IN-1:0]  b_r [COLS_A][COLS_B];
  logic signed [W_OUT-1:0] c_r [ROWS_A][COLS_B];
  logic signed [W_ACC-1:0] acc_r;
  logic [RRW-1:0]          i_r;
  logic [RCW-1:0]          j_r;
  logic [KW-1:0]           k_r;
  logic                    busy_r;
  logic                    done_r;
  logic                    sat_r;
  logic signed [W_OUT-1:0] rd_data_r;

  logic signed [W_IN-1:0]  a_sel_s;
  logic signed [W_IN-1:0]  b_sel_s;
  logic signed [W_ACC-1:0] a_ext_s;
  logic signed [W_ACC-1:0] b_ext_s;
  logic signed [W_ACC-1:0] prod_s;
  logic signed [W_ACC-1:0] sum_s;
  logic signed [W_OUT-1:0] c_val_s;
  logic                    c_clip_s;
  logic                    last_k_s;
  logic                    last_j_s;
  logic                    last_i_s;
  logic                    load_in_range_s;
  logic                    load_ok_s;

  // True when the exact value lies outside the signed W_OUT range.
  function automatic logic sat_hit(input logic signed [W_ACC-1:0] v);
    longint vv;
    longint hi;
    longint lo;
    vv = longint'(v);
    hi = (64'sd1 <<< (W_OUT - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (W_OUT - 1));
    return (vv > hi) || (vv < lo);
  endfunction

  // Clips the exact value into the signed W_OUT range.
  function automatic logic signed [W_OUT-1:0] sat_clip(input logic signed [W_ACC-1:0] v);
    longint vv;
    longint hi;
    longint lo;
    vv = longint'(v);
    hi = (64'sd1 <<< (W_OUT - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (W_OUT - 1));
    if (vv > hi) begin
      return W_OUT'(hi);
    end else if (vv < lo) begin
      return W_OUT'(lo);
    end else begin
      return W_OUT'(vv);
    end
  endfunction

  // Operand fetch, MAC datapath and loop-end detection for the current i/j/k.
  always_comb begin
    a_sel_s = '0;
    b_sel_s = '0;
    for (int r = 0; r < ROWS_A; r++) begin
      for (int c = 0; c < COLS_A; c++) begin
        a_sel_s = ((int'(i_r) == r) && (int'(k_r) == c)) ? a_r[r][c] : a_sel_s;
      end
    end
    for (int r = 0; r < COLS_A; r++) begin
      for (int c = 0; c < COLS_B; c++) begin
        b_sel_s = ((int'(k_r) == r) && (int'(j_r) == c)) ? b_r[r][c] : b_sel_s;
      end
    end
    a_ext_s  = W_ACC'(a_sel_s);
    b_ext_s  = W_ACC'(b_sel_s);
    prod_s   = a_ext_s * b_ext_s;
    sum_s    = acc_r + prod_s;
    c_val_s  = sat_clip(sum_s);
    c_clip_s = sat_hit(sum_s);
    last_k_s = (int'(k_r) == COLS_A - 1);
    last_j_s = (int'(j_r) == COLS_B - 1);
    last_i_s = (int'(i_r) == ROWS_A - 1);
  end

  // Load qualification: idle only, and the index must fall inside the chosen matrix.
  always_comb begin
    load_in_range_s = 1'b0;
    if (load_sel == 1'b0) begin
      load_in_range_s = (int'(load_row) < ROWS_A) && (int'(load_col) < COLS_A);
    end else begin
      load_in_range_s = (int'(load_row) < COLS_A) && (int'(load_col) < COLS_B);
    end
    load_ok_s = load_valid && (state_r == ST_IDLE) && load_in_range_s;
  end

  // Control FSM: loop counters, accumulator, handshake and sticky saturation flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      sat_r   <= 1'b0;
      acc_r   <= '0;
      i_r     <= '0;
      j_r     <= '0;
      k_r     <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            state_r <= ST_COMPUTE;
            busy_r  <= 1'b1;
            sat_r   <= 1'b0;
            acc_r   <= '0;
            i_r     <= '0;
            j_r     <= '0;
            k_r     <= '0;
          end
        end
        ST_COMPUTE: begin
          if (last_k_s) begin
            acc_r <= '0;
            k_r   <= '0;
            if (c_clip_s) begin
              sat_r <= 1'b1;
            end
            if (last_j_s) begin
              j_r <= '0;
              if (last_i_s) begin
                i_r     <= '0;
                state_r <= ST_DONE;
                busy_r  <= 1'b0;
                done_r  <= 1'b1;
              end else begin
                i_r <= i_r + 1'b1;
              end
            end else begin
              j_r <= j_r + 1'b1;
            end
          end else begin
            acc_r <= sum_s;
            k_r   <= k_r + 1'b1;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  // A and B storage, written only by qualified loads.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < ROWS_A; r++) begin
        for (int c = 0; c < COLS_A; c++) begin
          a_r[r][c] <= '0;
        end
      end
      for (int r = 0; r < COLS_A; r++) begin
        for (int c = 0; c < COLS_B; c++) begin
          b_r[r][c] <= '0;
        end
      end
    end else if (load_ok_s) begin
      for (int r = 0; r < ROWS_A; r++) begin
        for (int c = 0; c < COLS_A; c++) begin
          if (!load_sel && (int'(load_row) == r) && (int'(load_col) == c)) begin
            a_r[r][c] <= load_data;
          end
        end
      end
      for (int r = 0; r < COLS_A; r++) begin
        for (int c = 0; c < COLS_B; c++) begin
          if (load_sel && (int'(load_row) == r) && (int'(load_col) == c)) begin
            b_r[r][c] <= load_data;
          end
        end
      end
    end
  end

  // C storage: the saturated dot product lands on the last k step of each element.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < ROWS_A; r++) begin
        for (int c = 0; c < COLS_B; c++) begin
          c_r[r][c] <= '0;
        end
      end
    end else if ((state_r == ST_COMPUTE) && last_k_s) begin
      for (int r = 0; r < ROWS_A; r++) begin
        for (int c = 0; c < COLS_B; c++) begin
          if ((int'(i_r) == r) && (int'(j_r) == c)) begin
            c_r[r][c] <= c_val_s;
          end
        end
      end
    end
  end

  // Registered readout of C; out-of-range indices return zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_r <= '0;
    end else begin
      rd_data_r <= '0;
      for (int r = 0; r < ROWS_A; r++) begin
        for (int c = 0; c < COLS_B; c++) begin
          if ((int'(rd_row) == r) && (int'(rd_col) == c)) begin
            rd_data_r <= c_r[r][c];
          end
        end
      end
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign sat_flag = sat_r;
  assign rd_data  = rd_data_r;

endmodule

// File: tb/tb_matrix_mac_engine.sv
// tb_matrix_mac_engine: randomized and directed bench for matrix_mac_engine.
// Instance 0 uses the default 2x2x2 shape, instance 1 a 2x3 by 3x1 shape with a
// 16-bit output. Expected C values come from plain integer matrix products with
// clamping, and handshake timing from the cycle count N = ROWS_A*COLS_B*COLS_A.
module tb_matrix_mac_engine;

  logic clk = 1'b0;
  logic reset;

  logic              lv0, ls0, st0, busy0, done0, sat0;
  logic [0:0]        lr0, lc0, rr0, rc0;
  logic signed [7:0] ld0;
  logic signed [16:0] rd0;

  logic              lv1, ls1, st1, busy1, done1, sat1;
  logic [1:0]        lr1, lc1;
  logic [0:0]        rr1, rc1;
  logic signed [7:0] ld1;
  logic signed [15:0] rd1;

  int n_checks = 0;
  int n_errors = 0;

  int a0 [2][2];
  int b0 [2][2];
  int a1 [2][3];
  int b1 [3][1];

  always #5 clk = ~clk;

  matrix_mac_engine u_dut0 (
    .clk(clk), .reset(reset), .load_valid(lv0), .load_sel(ls0), .load_row(lr0),
    .load_col(lc0), .load_data(ld0), .start(st0), .busy(busy0), .done(done0),
    .sat_flag(sat0), .rd_row(rr0), .rd_col(rc0), .rd_data(rd0)
  );

  matrix_mac_engine #(.W_IN(8), .W_OUT(16), .ROWS_A(2), .COLS_A(3), .COLS_B(1)) u_dut1 (
    .clk(clk), .reset(reset), .load_valid(lv1), .load_sel(ls1), .load_row(lr1),
    .load_col(lc1), .load_data(ld1), .start(st1), .busy(busy1), .done(done1),
    .sat_flag(sat1), .rd_row(rr1), .rd_col(rc1), .rd_data(rd1)
  );

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint sat_ref(input longint v, input int w);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -(longint'(1) <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic longint raw0(input int r, input int c);
    longint s = 0;
    for (int k = 0; k < 2; k++) s += longint'(a0[r][k]) * longint'(b0[k][c]);
    return s;
  endfunction

  function automatic longint raw1(input int r);
    longint s = 0;
    for (int k = 0; k < 3; k++) s += longint'(a1[r][k]) * longint'(b1[k][0]);
    return s;
  endfunction

  function automatic int any_sat0();
    int f = 0;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++)
        if (sat_ref(raw0(r, c), 17) != raw0(r, c)) f = 1;
    return f;
  endfunction

  function automatic int any_sat1();
    int f = 0;
    for (int r = 0; r < 2; r++)
      if (sat_ref(raw1(r), 16) != raw1(r)) f = 1;
    return f;
  endfunction

  function automatic int rnd8();
    return int'($urandom_range(255)) - 128;
  endfunction

  // Drives one load cycle (called at a negedge, returns at the next negedge).
  task automatic drive_load(input int which, input int sel, input int row, input int col, input int data);
    if (which == 0) begin
      lv0 = 1'b1; ls0 = sel[0]; lr0 = row[0]; lc0 = col[0]; ld0 = data[7:0];
    end else begin
      lv1 = 1'b1; ls1 = sel[0]; lr1 = row[1:0]; lc1 = col[1:0]; ld1 = data[7:0];
    end
    @(negedge clk);
    lv0 = 1'b0;
    lv1 = 1'b0;
  endtask

  task automatic mload0(input int sel, input int r, input int c, input int v);
    drive_load(0, sel, r, c, v);
    if (sel == 0) a0[r][c] = v; else b0[r][c] = v;
  endtask

  task automatic mload1(input int sel, input int r, input int c, input int v);
    drive_load(1, sel, r, c, v);
    if (sel == 0) a1[r][c] = v; else b1[r][c] = v;
  endtask

  task automatic read_chk(input int which, input int r, input int c, input longint exp, input string tag);
    longint obs;
    if (which == 0) begin rr0 = r[0]; rc0 = c[0]; end
    else begin rr1 = r[0]; rc1 = c[0]; end
    @(negedge clk);
    obs = (which == 0) ? longint'(rd0) : longint'(rd1);
    check_eq(tag, obs, exp);
  endtask

  task automatic check_c0(input string tag);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++)
        read_chk(0, r, c, sat_ref(raw0(r, c), 17), $sformatf("%s_c%0d%0d", tag, r, c));
    check_eq({tag, "_sat"}, longint'(sat0), longint'(any_sat0()));
  endtask

  task automatic check_c1(input string tag);
    for (int r = 0; r < 2; r++)
      read_chk(1, r, 0, sat_ref(raw1(r), 16), $sformatf("%s_c%0d", tag, r));
    check_eq({tag, "_sat"}, longint'(sat1), longint'(any_sat1()));
  endtask

  // mode 0: plain start; 1: start+load injected while busy; 2: load A[0][0]=10 with start.
  task automatic run(input int which, input int n, input int mode, input string tag);
    int busy_cnt = 0;
    int done_cnt = 0;
    int done_at = -1;
    int busy_at_done = 0;
    int b;
    int d;
    if (which == 0) st0 = 1'b1; else st1 = 1'b1;
    if (mode == 2) begin
      if (which == 0) begin lv0 = 1'b1; ls0 = 1'b0; lr0 = 1'b0; lc0 = 1'b0; ld0 = 8'sd10; end
      else begin lv1 = 1'b1; ls1 = 1'b0; lr1 = 2'd0; lc1 = 2'd0; ld1 = 8'sd10; end
    end
    @(negedge clk);
    st0 = 1'b0; st1 = 1'b0; lv0 = 1'b0; lv1 = 1'b0;
    for (int t = 0; t < n + 4; t++) begin
      b = (which == 0) ? int'(busy0) : int'(busy1);
      d = (which == 0) ? int'(done0) : int'(done1);
      if (b != 0) busy_cnt++;
      if (d != 0) begin
        done_cnt++;
        if (done_at < 0) begin done_at = t; busy_at_done = b; end
      end
      if (mode == 1 && t == 2) begin
        if (which == 0) begin st0 = 1'b1; lv0 = 1'b1; ls0 = 1'b0; lr0 = 1'b0; lc0 = 1'b0; ld0 = 8'sd99; end
        else begin st1 = 1'b1; lv1 = 1'b1; ls1 = 1'b0; lr1 = 2'd0; lc1 = 2'd0; ld1 = 8'sd99; end
      end else begin
        st0 = 1'b0; st1 = 1'b0; lv0 = 1'b0; lv1 = 1'b0;
      end
      @(negedge clk);
    end
    st0 = 1'b0; st1 = 1'b0; lv0 = 1'b0; lv1 = 1'b0;
    check_eq({tag, "_busy_cycles"}, busy_cnt, n);
    check_eq({tag, "_done_pulses"}, done_cnt, 1);
    check_eq({tag, "_done_cycle"}, done_at, n);
    check_eq({tag, "_busy_at_done"}, busy_at_done, 0);
  endtask

  task automatic load_all0();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        mload0(0, r, c, rnd8());
        mload0(1, r, c, rnd8());
      end
  endtask

  task automatic fill1(input int av, input int bv);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 3; c++) mload1(0, r, c, av);
    for (int k = 0; k < 3; k++) mload1(1, k, 0, bv);
  endtask

  task automatic clear_models();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin a0[r][c] = 0; b0[r][c] = 0; end
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 3; c++) a1[r][c] = 0;
    for (int k = 0; k < 3; k++) b1[k][0] = 0;
  endtask

  initial begin
    int done_seen;
    reset = 1'b1;
    lv0 = 1'b0; ls0 = 1'b0; lr0 = '0; lc0 = '0; ld0 = '0; st0 = 1'b0; rr0 = '0; rc0 = '0;
    lv1 = 1'b0; ls1 = 1'b0; lr1 = '0; lc1 = '0; ld1 = '0; st1 = 1'b0; rr1 = '0; rc1 = '0;
    clear_models();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset values
    check_eq("rst_busy0", busy0, 0);
    check_eq("rst_done0", done0, 0);
    check_eq("rst_sat0", sat0, 0);
    check_eq("rst_busy1", busy1, 0);
    check_eq("rst_sat1", sat1, 0);
    check_c0("rst0");
    check_c1("rst1");

    // Directed 2x2 product
    mload0(0, 0, 0, 1); mload0(0, 0, 1, 2); mload0(0, 1, 0, 3); mload0(0, 1, 1, 4);
    mload0(1, 0, 0, 5); mload0(1, 0, 1, 6); mload0(1, 1, 0, 7); mload0(1, 1, 1, 8);
    run(0, 8, 0, "dir");
    check_c0("dir");

    // Negative operand
    mload0(0, 0, 0, -3);
    run(0, 8, 0, "neg");
    check_c0("neg");

    // Start and load while busy are ignored; a rerun proves A is unchanged
    run(0, 8, 1, "ign");
    check_c0("ign");
    run(0, 8, 0, "ign2");
    check_c0("ign2");

    // Randomized 2x2 products
    for (int it = 0; it < 6; it++) begin
      load_all0();
      run(0, 8, 0, $sformatf("rnd%0d", it));
      check_c0($sformatf("rnd%0d", it));
    end

    // Load together with start, B = identity
    load_all0();
    mload0(1, 0, 0, 1); mload0(1, 0, 1, 0); mload0(1, 1, 0, 0); mload0(1, 1, 1, 1);
    a0[0][0] = 10;
    run(0, 8, 2, "ldst");
    check_c0("ldst");

    // Reset during the 4th compute cycle
    load_all0();
    st0 = 1'b1;
    @(negedge clk);
    st0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    clear_models();
    done_seen = 0;
    check_eq("abort_busy", busy0, 0);
    for (int t = 0; t < 12; t++) begin
      if (done0) done_seen++;
      @(negedge clk);
    end
    check_eq("abort_no_done", done_seen, 0);
    check_c0("abort");
    load_all0();
    run(0, 8, 0, "post");
    check_c0("post");

    // Non-square shape: positive saturation
    fill1(-128, -128);
    run(1, 6, 0, "satp");
    check_c1("satp");
    read_chk(1, 0, 1, 0, "oor_read");

    // All ones plus out-of-range loads that must be dropped
    fill1(1, 1);
    drive_load(1, 0, 3, 0, 55);
    drive_load(1, 0, 2, 1, 55);
    drive_load(1, 1, 3, 0, 55);
    drive_load(1, 1, 0, 1, 55);
    run(1, 6, 0, "ones");
    check_c1("ones");

    // Negative saturation
    fill1(-128, 127);
    run(1, 6, 0, "satn");
    check_c1("satn");

    // Randomized non-square products
    for (int it = 0; it < 4; it++) begin
      for (int r = 0; r < 2; r++)
        for (int c = 0; c < 3; c++) mload1(0, r, c, rnd8());
      for (int k = 0; k < 3; k++) mload1(1, k, 0, rnd8());
      run(1, 6, 0, $sformatf("nrnd%0d", it));
      check_c1($sformatf("nrnd%0d", it));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
